// File: rtl/keypad_defs.sv
// Shared definitions for the keypad front end: FSM states, code width, defaults.
package keypad_defs;

    localparam int BCD_W               = 4;
    localparam int DEF_NUM_KEYS        = 10;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE,
        ST_LOCKOUT
    } kp_state_e;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser bank for raw asynchronous key lines.
module key_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// Debounces ten digit keys, rejects multi-key presses and emits one BCD strobe
// per clean press.
module keypad_encoder
    import keypad_defs::*;
#(
    parameter int NUM_KEYS        = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 4
) (
    input  logic                clock,
    input  logic                clear_n,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [BCD_W-1:0]    bcd,
    output logic                key_valid,
    output logic                key_held,
    output logic                multi_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [NUM_KEYS-1:0] s;
    kp_state_e           state, state_d;
    logic [CNT_W-1:0]    count, count_d;
    logic [BCD_W-1:0]    cand, cand_d;
    logic [BCD_W-1:0]    bcd_d;
    logic                valid_d, err_d;

    logic                s_zero, s_one_hot, s_match;
    logic [BCD_W-1:0]    s_idx;

    key_sync #(.WIDTH(NUM_KEYS)) u_sync (
        .clock   (clock),
        .clear_n (clear_n),
        .d       (keys),
        .q       (s)
    );

    // A vector is one-hot when it is non-zero and clearing its lowest set bit
    // leaves nothing behind.
    assign s_zero    = (s == '0);
    assign s_one_hot = !s_zero && ((s & (s - NUM_KEYS'(1))) == '0);
    assign s_match   = (s == (NUM_KEYS'(1) << cand));

    // Index of the set bit; only meaningful when s is one-hot.
    always_comb begin
        s_idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (s[i]) s_idx = BCD_W'(i);
        end
    end

    // State, counter, candidate and registered output strobes.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            cand      <= '0;
            bcd       <= '0;
            key_valid <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            cand      <= cand_d;
            bcd       <= bcd_d;
            key_valid <= valid_d;
            multi_err <= err_d;
        end
    end

    // Next-state logic; the counter is reused by DEBOUNCE, RELEASE and LOCKOUT
    // and saturates rather than wrapping.
    always_comb begin
        state_d = state;
        count_d = count;
        cand_d  = cand;
        bcd_d   = bcd;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_one_hot) begin
                    cand_d  = s_idx;
                    count_d = CNT_ONE;
                    state_d = ST_DEBOUNCE;
                end else if (!s_zero) begin
                    err_d   = 1'b1;
                    count_d = '0;
                    state_d = ST_LOCKOUT;
                end
            end
            ST_DEBOUNCE: begin
                if (s_match) begin
                    if (count == CNT_LAST) begin
                        bcd_d   = cand;
                        valid_d = 1'b1;
                        state_d = ST_PRESSED;
                    end else if (count != CNT_MAX) begin
                        count_d = count + CNT_ONE;
                    end
                end else if (s_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    err_d   = 1'b1;
                    count_d = '0;
                    state_d = ST_LOCKOUT;
                end
            end
            ST_PRESSED: begin
                // Extra keys while held are ignored; only a full release matters.
                if (s_zero) begin
                    count_d = CNT_ONE;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE, ST_LOCKOUT: begin
                if (s_zero) begin
                    if (count == CNT_LAST) begin
                        state_d = ST_IDLE;
                    end else if (count != CNT_MAX) begin
                        count_d = count + CNT_ONE;
                    end
                end else begin
                    count_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign key_held = (state == ST_PRESSED);

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: directed scenarios plus random key
// traffic, all compared against a run-length behavioural model.
module tb_keypad_encoder;

    localparam int NK = 10;
    localparam int D  = 4;

    logic          clock   = 1'b0;
    logic          clear_n = 1'b0;
    logic [NK-1:0] keys    = '0;
    logic [3:0]    bcd;
    logic          key_valid, key_held, multi_err;

    keypad_encoder #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .keys      (keys),
        .bcd       (bcd),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_err (multi_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Behavioural model: a two-deep sample delay, then run-length rules.
    logic [NK-1:0] m_s1 = '0, m_s2 = '0;
    bit            m_held = 0, m_wait = 0;
    int            m_run = 0, m_quiet = 0, m_cand = 0;
    logic [3:0]    exp_bcd = '0;
    logic          exp_valid = 1'b0, exp_err = 1'b0;

    // Per-run statistics gathered by drive(), judged by each test task.
    int            cyc = 0, mism = 0, n_valid = 0, n_err = 0, n_both = 0;
    int            n_exp_valid = 0, n_exp_err = 0, v_cyc = -1;
    logic [3:0]    v_bcd = '0;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_held = 0; m_wait = 0;
        m_run = 0; m_quiet = 0; m_cand = 0;
        exp_bcd = '0; exp_valid = 1'b0; exp_err = 1'b0;
    endtask

    task automatic model_step();
        logic [NK-1:0] s;
        logic [NK-1:0] cand_vec;
        s = m_s2; m_s2 = m_s1; m_s1 = keys;
        cand_vec  = NK'(1) << m_cand;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (m_held) begin
            if (s == '0) begin m_held = 0; m_wait = 1; m_quiet = 1; end
        end else if (m_wait) begin
            // Need D consecutive quiet samples before a new press is looked at.
            if (s == '0) begin
                m_quiet++;
                if (m_quiet >= D) m_wait = 0;
            end else m_quiet = 0;
        end else if ($countones(s) > 1 || (m_run > 0 && s != '0 && s != cand_vec)) begin
            exp_err = 1'b1; m_run = 0; m_wait = 1; m_quiet = 0;
        end else if (s == '0) begin
            m_run = 0;
        end else if (m_run == 0) begin
            for (int i = 0; i < NK; i++) if (s[i]) m_cand = i;
            m_run = 1;
        end else begin
            m_run++;
            if (m_run == D) begin
                exp_valid = 1'b1; exp_bcd = 4'(m_cand); m_held = 1; m_run = 0;
            end
        end
    endtask

    task automatic clr_stats();
        mism = 0; n_valid = 0; n_err = 0; n_both = 0;
        n_exp_valid = 0; n_exp_err = 0; v_cyc = -1;
    endtask

    // Apply k for n clock edges starting from a falling edge, tracking model
    // agreement and observed strobes.
    task automatic drive(input logic [NK-1:0] k, input int n);
        keys = k;
        repeat (n) begin
            @(posedge clock);
            model_step();
            @(negedge clock);
            if ({bcd, key_valid, key_held, multi_err} !== {exp_bcd, exp_valid, m_held, exp_err})
                mism++;
            if (key_valid === 1'b1) begin n_valid++; v_cyc = cyc; v_bcd = bcd; end
            if (multi_err === 1'b1) n_err++;
            if (key_valid === 1'b1 && multi_err === 1'b1) n_both++;
            if (exp_valid) n_exp_valid++;
            if (exp_err) n_exp_err++;
            cyc++;
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0; keys = '0; model_reset();
        repeat (3) @(negedge clock);
        total++;
        if ({bcd, key_valid, key_held, multi_err} !== 7'b0) begin
            bad++; $display("FAIL reset_outputs: got %b want 0000000", {bcd, key_valid, key_held, multi_err});
        end
        clear_n = 1'b1;
        clr_stats();
        drive('0, 4);
        total++;
        if (mism !== 0) begin bad++; $display("FAIL reset_idle: mismatching cycles %0d want 0", mism); end
    endtask

    task automatic test_clean_press();
        logic [NK-1:0] k3;
        int t0;
        k3 = 10'b0000001000;
        clr_stats(); t0 = cyc;
        drive(k3, 20);
        total++; if (n_valid !== 1) begin bad++; $display("FAIL clean_count: got %0d want 1", n_valid); end
        total++; if (v_cyc - t0 !== 5) begin bad++; $display("FAIL clean_latency: got %0d want 5", v_cyc - t0); end
        total++; if (v_bcd !== 4'd3) begin bad++; $display("FAIL clean_bcd: got %0d want 3", v_bcd); end
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL clean_held: got %b want 1", key_held); end
        drive('0, 8);
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL clean_unheld: got %b want 0", key_held); end
        total++; if (bcd !== 4'd3) begin bad++; $display("FAIL clean_bcd_hold: got %0d want 3", bcd); end
        total++; if (n_err !== 0) begin bad++; $display("FAIL clean_err: got %0d want 0", n_err); end
        total++; if (mism !== 0) begin bad++; $display("FAIL clean_model: mismatching cycles %0d want 0", mism); end
    endtask

    task automatic test_bounce();
        logic [NK-1:0] k7;
        int t0;
        k7 = NK'(1) << 7;
        clr_stats();
        for (int i = 0; i < 3; i++) begin drive(k7, 2); drive('0, 1); end
        total++; if (n_valid !== 0) begin bad++; $display("FAIL bounce_early: got %0d strobes want 0", n_valid); end
        t0 = cyc;
        drive(k7, 8 + int'($urandom_range(0, 6)));
        drive('0, 8);
        total++; if (n_valid !== 1) begin bad++; $display("FAIL bounce_count: got %0d want 1", n_valid); end
        total++; if (v_cyc - t0 !== 5) begin bad++; $display("FAIL bounce_latency: got %0d want 5", v_cyc - t0); end
        total++; if (v_bcd !== 4'd7) begin bad++; $display("FAIL bounce_bcd: got %0d want 7", v_bcd); end
        total++; if (mism !== 0) begin bad++; $display("FAIL bounce_model: mismatching cycles %0d want 0", mism); end
    endtask

    task automatic test_multi();
        logic [NK-1:0] k25, k9;
        int t0;
        k25 = (NK'(1) << 2) | (NK'(1) << 5);
        k9  = NK'(1) << 9;
        clr_stats();
        drive(k25, 3);
        drive('0, 4);
        total++; if (n_err !== 1) begin bad++; $display("FAIL multi_err: got %0d pulses want 1", n_err); end
        total++; if (n_valid !== 0) begin bad++; $display("FAIL multi_valid: got %0d want 0", n_valid); end
        t0 = cyc;
        drive(k9, 10);
        drive('0, 8);
        total++; if (n_valid !== 1 || v_bcd !== 4'd9) begin
            bad++; $display("FAIL multi_then9: got %0d strobes bcd %0d want 1 strobe bcd 9", n_valid, v_bcd);
        end
        total++; if (v_cyc - t0 !== 5) begin bad++; $display("FAIL multi_latency: got %0d want 5", v_cyc - t0); end
        total++; if (n_both !== 0) begin bad++; $display("FAIL multi_both: got %0d want 0", n_both); end
        total++; if (mism !== 0) begin bad++; $display("FAIL multi_model: mismatching cycles %0d want 0", mism); end
    endtask

    task automatic test_release_bounce();
        logic [NK-1:0] k1;
        int t0;
        k1 = NK'(1) << 1;
        clr_stats();
        drive(k1, 8);
        for (int i = 0; i < 6; i++) drive((i % 2 == 0) ? '0 : k1, 1);
        // Three quiet samples are not enough; this press must be swallowed.
        drive('0, 3);
        drive(k1, 8);
        total++; if (n_valid !== 1) begin bad++; $display("FAIL relbounce_count: got %0d want 1", n_valid); end
        drive('0, 4);
        t0 = cyc;
        drive(k1, 10);
        drive('0, 8);
        total++; if (n_valid !== 2) begin bad++; $display("FAIL relbounce_repress: got %0d want 2", n_valid); end
        total++; if (v_cyc - t0 !== 5) begin bad++; $display("FAIL relbounce_latency: got %0d want 5", v_cyc - t0); end
        total++; if (mism !== 0) begin bad++; $display("FAIL relbounce_model: mismatching cycles %0d want 0", mism); end
    endtask

    task automatic test_reset_mid();
        logic [NK-1:0] k4;
        int t0;
        k4 = NK'(1) << 4;
        clr_stats();
        drive(k4, 3);
        #2 clear_n = 1'b0; model_reset();
        #1;
        total++; if ({bcd, key_valid, key_held, multi_err} !== 7'b0) begin
            bad++; $display("FAIL rst_debounce: got %b want 0000000", {bcd, key_valid, key_held, multi_err});
        end
        @(negedge clock) clear_n = 1'b1;
        total++; if (n_valid !== 0) begin bad++; $display("FAIL rst_debounce_strobe: got %0d want 0", n_valid); end
        clr_stats(); t0 = cyc;
        drive(k4, 10);
        total++; if (n_valid !== 1 || v_bcd !== 4'd4 || v_cyc - t0 !== 5) begin
            bad++; $display("FAIL rst_redebounce: got %0d strobes bcd %0d at %0d want 1 bcd 4 at 5", n_valid, v_bcd, v_cyc - t0);
        end
        #2 clear_n = 1'b0; model_reset();
        #1;
        total++; if ({bcd, key_valid, key_held, multi_err} !== 7'b0) begin
            bad++; $display("FAIL rst_pressed: got %b want 0000000", {bcd, key_valid, key_held, multi_err});
        end
        @(negedge clock) clear_n = 1'b1;
        clr_stats(); t0 = cyc;
        drive(k4, 10);
        drive('0, 8);
        total++; if (n_valid !== 1 || v_cyc - t0 !== 5) begin
            bad++; $display("FAIL rst_pressed_again: got %0d strobes at %0d want 1 at 5", n_valid, v_cyc - t0);
        end
        total++; if (mism !== 0) begin bad++; $display("FAIL rst_model: mismatching cycles %0d want 0", mism); end
    endtask

    task automatic test_held_add();
        logic [NK-1:0] k6, k68;
        k6  = NK'(1) << 6;
        k68 = k6 | (NK'(1) << 8);
        clr_stats();
        drive(k6, 10);
        drive(k68, 6);
        total++; if (key_held !== 1'b1 || bcd !== 4'd6) begin
            bad++; $display("FAIL held_add_state: got held %b bcd %0d want held 1 bcd 6", key_held, bcd);
        end
        drive(k6, 3);
        drive('0, 8);
        total++; if (n_valid !== 1 || n_err !== 0) begin
            bad++; $display("FAIL held_add_strobes: got valid %0d err %0d want 1 and 0", n_valid, n_err);
        end
        total++; if (mism !== 0) begin bad++; $display("FAIL held_add_model: mismatching cycles %0d want 0", mism); end
    endtask

    task automatic test_random();
        logic [NK-1:0] k;
        int a, b;
        clr_stats();
        for (int it = 0; it < 60; it++) begin
            a = int'($urandom_range(0, NK - 1));
            b = (a + 1 + int'($urandom_range(0, NK - 2))) % NK;
            case ($urandom_range(0, 3))
                0: k = '0;
                1: k = NK'(1) << a;
                2: k = (NK'(1) << a) | (NK'(1) << b);
                default: k = ($urandom_range(0, 1) != 0) ? (NK'(1) << a) : '0;
            endcase
            drive(k, int'($urandom_range(1, 12)));
        end
        drive('0, 8);
        total++; if (mism !== 0) begin bad++; $display("FAIL random_model: mismatching cycles %0d want 0", mism); end
        total++; if (n_valid !== n_exp_valid) begin bad++; $display("FAIL random_valid: got %0d want %0d", n_valid, n_exp_valid); end
        total++; if (n_err !== n_exp_err) begin bad++; $display("FAIL random_err: got %0d want %0d", n_err, n_exp_err); end
        total++; if (n_both !== 0) begin bad++; $display("FAIL random_both: got %0d want 0", n_both); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi();
        test_release_bounce();
        test_reset_mid();
        test_held_add();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
